// File: rtl/sort_pkg.sv
// Shared types and constants for the sequential bubble-sort engine.
package sort_pkg;

    // Default geometry; instances normally override these.
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_DEPTH  = 100;

    // Engine phases: fill the buffer, sort in place, stream the result out.
    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_SORT  = 2'd1,
        S_DRAIN = 2'd2
    } sort_state_e;

    // Clocks spent in SORT for a fully reverse-ordered batch of `depth` words.
    function automatic int unsigned worst_sort_cycles(input int unsigned depth);
        return depth * (depth - 1) / 2;
    endfunction

endpackage

// File: rtl/compare_swap.sv
// Single compare-exchange element, shared by every step of the sort.
module compare_swap
    import sort_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] hi,
    output logic              swap
);

    // Strict compare keeps equal words in place, which makes the sort stable.
    always_comb begin
        swap = (a > b);
        lo   = swap ? b : a;
        hi   = swap ? a : b;
    end

endmodule

// File: rtl/bubble_sort_seq.sv
// Sequential bubble sort: load DEPTH words, sort in place with one shared
// compare-swap unit (one compare per clock), then stream them out ascending.
module bubble_sort_seq
    import sort_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic [31:0]       sort_cycles
);

    localparam int unsigned     IDX_W    = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    if (DEPTH < 2) begin : g_depth_check
        $error("bubble_sort_seq: DEPTH must be at least 2");
    end

    sort_state_e       state_q, state_d;
    logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
    logic [IDX_W-1:0]  j_q, j_d;
    logic [IDX_W-1:0]  limit_q, limit_d;
    logic              swapped_q, swapped_d;
    logic [31:0]       sort_cycles_q, sort_cycles_d;

    // Working buffer; contents are don't-care after reset.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0]  j_nxt;
    logic [DATA_W-1:0] cs_lo;
    logic [DATA_W-1:0] cs_hi;
    logic              cs_swap;
    logic              pass_end;
    logic              pass_swapped;
    logic              in_fire;
    logic              out_fire;

    assign j_nxt = j_q + 1'b1;

    compare_swap #(
        .DATA_W (DATA_W)
    ) u_compare_swap (
        .a    (mem[j_q]),
        .b    (mem[j_nxt]),
        .lo   (cs_lo),
        .hi   (cs_hi),
        .swap (cs_swap)
    );

    // Handshakes and status; every output is forced quiet while rst is held.
    always_comb begin
        in_ready    = !rst && (state_q == S_LOAD);
        out_valid   = !rst && (state_q == S_DRAIN);
        busy        = !rst && ((state_q == S_SORT) || (state_q == S_DRAIN));
        out_data    = out_valid ? mem[rd_idx_q] : '0;
        out_last    = out_valid && (rd_idx_q == LAST_IDX);
        sort_cycles = sort_cycles_q;
        in_fire     = in_valid && in_ready;
        out_fire    = out_valid && out_ready;
    end

    // Pass bookkeeping: the flag seen at pass end must include this cycle's swap.
    always_comb begin
        pass_end     = (j_q == limit_q - 1'b1);
        pass_swapped = swapped_q || cs_swap;
    end

    // Next-state logic for the load / sort / drain sequence.
    always_comb begin
        state_d       = state_q;
        wr_idx_d      = wr_idx_q;
        rd_idx_d      = rd_idx_q;
        j_d           = j_q;
        limit_d       = limit_q;
        swapped_d     = swapped_q;
        sort_cycles_d = sort_cycles_q;

        unique case (state_q)
            S_LOAD: begin
                if (in_fire) begin
                    if (wr_idx_q == LAST_IDX) begin
                        state_d       = S_SORT;
                        wr_idx_d      = '0;
                        j_d           = '0;
                        limit_d       = LAST_IDX;
                        swapped_d     = 1'b0;
                        sort_cycles_d = '0;
                    end else begin
                        wr_idx_d = wr_idx_q + 1'b1;
                    end
                end
            end

            S_SORT: begin
                sort_cycles_d = sort_cycles_q + 32'd1;
                if (!pass_end) begin
                    j_d       = j_nxt;
                    swapped_d = pass_swapped;
                end else if (!pass_swapped || (limit_q == ONE_IDX)) begin
                    // A clean pass means the buffer is ordered; stop early.
                    state_d   = S_DRAIN;
                    rd_idx_d  = '0;
                    swapped_d = 1'b0;
                end else begin
                    // Largest remaining word has bubbled to limit; shrink the window.
                    limit_d   = limit_q - 1'b1;
                    j_d       = '0;
                    swapped_d = 1'b0;
                end
            end

            S_DRAIN: begin
                if (out_fire) begin
                    if (rd_idx_q == LAST_IDX) begin
                        state_d  = S_LOAD;
                        wr_idx_d = '0;
                        rd_idx_d = '0;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_LOAD;
            wr_idx_q      <= '0;
            rd_idx_q      <= '0;
            j_q           <= '0;
            limit_q       <= LAST_IDX;
            swapped_q     <= 1'b0;
            sort_cycles_q <= '0;
        end else begin
            state_q       <= state_d;
            wr_idx_q      <= wr_idx_d;
            rd_idx_q      <= rd_idx_d;
            j_q           <= j_d;
            limit_q       <= limit_d;
            swapped_q     <= swapped_d;
            sort_cycles_q <= sort_cycles_d;
        end
    end

    // Buffer writes: input words during LOAD, compare-swap results during SORT.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (in_fire) begin
                mem[wr_idx_q] <= in_data;
            end
            if (state_q == S_SORT) begin
                mem[j_q]   <= cs_lo;
                mem[j_nxt] <= cs_hi;
            end
        end
    end

endmodule

// File: tb/tb_bubble_sort_seq.sv
// Self-checking bench for bubble_sort_seq: a DEPTH=4 and a DEPTH=100 instance
// share one stimulus path; results are compared with a sorted-queue model.
module tb_bubble_sort_seq;
    import sort_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          sel = 0;  // 0 selects the DEPTH=4 instance, 1 the DEPTH=100 one
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic        in_valid4, in_ready4, out_valid4, out_last4, busy4;
    logic [31:0] out_data4, sort_cycles4;
    logic        in_valid100, in_ready100, out_valid100, out_last100, busy100;
    logic [31:0] out_data100, sort_cycles100;

    logic        cur_in_ready, cur_out_valid, cur_out_last, cur_busy;
    logic [31:0] cur_out_data, cur_sort_cycles;

    assign in_valid4       = in_valid && (sel == 0);
    assign in_valid100     = in_valid && (sel == 1);
    assign cur_in_ready    = (sel == 1) ? in_ready100    : in_ready4;
    assign cur_out_valid   = (sel == 1) ? out_valid100   : out_valid4;
    assign cur_out_last    = (sel == 1) ? out_last100    : out_last4;
    assign cur_busy        = (sel == 1) ? busy100        : busy4;
    assign cur_out_data    = (sel == 1) ? out_data100    : out_data4;
    assign cur_sort_cycles = (sel == 1) ? sort_cycles100 : sort_cycles4;

    always #5 clk = ~clk;

    bubble_sort_seq #(.DATA_W(32), .DEPTH(4)) u_dut4 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid4),
        .in_ready    (in_ready4),
        .in_data     (in_data),
        .out_valid   (out_valid4),
        .out_ready   (out_ready),
        .out_data    (out_data4),
        .out_last    (out_last4),
        .busy        (busy4),
        .sort_cycles (sort_cycles4)
    );

    bubble_sort_seq #(.DATA_W(32), .DEPTH(100)) u_dut100 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid100),
        .in_ready    (in_ready100),
        .in_data     (in_data),
        .out_valid   (out_valid100),
        .out_ready   (out_ready),
        .out_data    (out_data100),
        .out_last    (out_last100),
        .busy        (busy100),
        .sort_cycles (sort_cycles100)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bubble sort with early exit: passes that swap = largest count of strictly
    // greater words sitting left of any word; one clean pass follows unless the
    // window has already shrunk to a single compare. Pass k costs n-k compares.
    function automatic int unsigned model_cycles(input logic [31:0] w[$]);
        int unsigned n, p, passes, tot;
        n = w.size();
        p = 0;
        tot = 0;
        for (int i = 0; i < w.size(); i++) begin
            int unsigned cnt = 0;
            for (int k = 0; k < i; k++) if (w[k] > w[i]) cnt++;
            if (cnt > p) p = cnt;
        end
        passes = (p + 1 < n - 1) ? p + 1 : n - 1;
        for (int unsigned k = 1; k <= passes; k++) tot += n - k;
        return tot;
    endfunction

    // Entry/exit point of every task: #1 after a rising edge.
    task automatic load_words(input logic [31:0] w[$], input bit gaps);
        int k = 0;
        int guard = 0;
        while (k < w.size() && guard < 2000) begin
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = w[k];
            @(negedge clk);
            if (in_valid && cur_in_ready) k++;
            guard++;
            @(posedge clk); #1;
        end
        if (k < w.size()) check("load_timeout", 64'(k), 64'(w.size()));
    endtask

    task automatic drain_words(input int depth, input int mode, input bit keep,
                               input logic [31:0] nf, output logic [31:0] got[$]);
        int          c = 0;
        bit          pend = 0;
        logic [31:0] pd = '0;
        logic        pl = 1'b0;
        got = {};
        while (got.size() < depth && c < 12000) begin
            in_valid  = keep;
            in_data   = nf;
            out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 3 == 0) : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (pend) begin
                check("stall_valid", 64'(cur_out_valid), 64'(1));
                check("stall_data", 64'(cur_out_data), 64'(pd));
                check("stall_last", 64'(cur_out_last), 64'(pl));
            end
            pend = 0;
            if (cur_out_valid) begin
                if (keep) check("no_overlap_in_ready", 64'(cur_in_ready), 64'(0));
                if (out_ready) begin
                    check("out_last", 64'(cur_out_last), 64'(got.size() == depth - 1));
                    got.push_back(cur_out_data);
                end else begin
                    pend = 1;
                    pd   = cur_out_data;
                    pl   = cur_out_last;
                end
            end
            c++;
            @(posedge clk); #1;
        end
        if (got.size() < depth) check("drain_timeout", 64'(got.size()), 64'(depth));
    endtask

    task automatic run_batch(input int sel_i, input logic [31:0] w[$], input int mode,
                             input bit gaps, input bit keep, input logic [31:0] nf);
        logic [31:0] got[$];
        logic [31:0] exp[$];
        int          depth;
        sel   = sel_i;
        depth = (sel_i == 1) ? 100 : 4;
        load_words(w, gaps);
        drain_words(depth, mode, keep, nf, got);
        check("drain_end_valid", 64'(cur_out_valid), 64'(0));
        check("drain_end_ready", 64'(cur_in_ready), 64'(1));
        out_ready = 1'b0;
        if (!keep) in_valid = 1'b0;
        exp = w;
        exp.sort();
        for (int i = 0; i < depth; i++) begin
            if (i < got.size()) check("word", 64'(got[i]), 64'(exp[i]));
        end
        check("sort_cycles", 64'(cur_sort_cycles), 64'(model_cycles(w)));
    endtask

    initial begin
        logic [31:0] w[$];
        logic [31:0] w2[$];
        bit          saw_out;

        // Reset state, sampled while rst is still asserted.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready4), 64'(0));
        check("rst_out_valid", 64'(out_valid4), 64'(0));
        check("rst_out_last", 64'(out_last4), 64'(0));
        check("rst_busy", 64'(busy100), 64'(0));
        check("rst_out_data", 64'(out_data100), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready4), 64'(1));
        check("post_rst_sort_cycles", 64'(sort_cycles4), 64'(0));
        @(posedge clk); #1;

        // DEPTH=4 basic case.
        w = '{32'd3, 32'd1, 32'd2, 32'd0};
        run_batch(0, w, 0, 0, 0, '0);
        check("d4_cycles_spec", 64'(cur_sort_cycles), 64'(6));

        // Duplicates and the unsigned extreme, then a back-to-back batch with in_valid held.
        w  = '{32'd7, 32'd7, 32'd1, 32'hFFFF_FFFF};
        w2 = '{32'd9, 32'd5, 32'd5, 32'd2};
        run_batch(0, w, 0, 0, 1, w2[0]);
        run_batch(0, w2, 0, 0, 0, '0);

        // Backpressure pattern 1,0,0,1,0,0,...
        w = '{32'd40, 32'd10, 32'd30, 32'd20};
        run_batch(0, w, 1, 0, 0, '0);

        // DEPTH=100 ascending and descending.
        w = {};
        for (int i = 1; i <= 100; i++) w.push_back(32'(i));
        run_batch(1, w, 0, 0, 0, '0);
        check("d100_sorted_cycles", 64'(cur_sort_cycles), 64'(99));
        w = {};
        for (int i = 100; i >= 1; i--) w.push_back(32'(i));
        run_batch(1, w, 0, 0, 0, '0);
        check("d100_worst_cycles", 64'(cur_sort_cycles), 64'(worst_sort_cycles(100)));

        // Randomized DEPTH=100 batches with input gaps and random backpressure.
        for (int b = 0; b < 3; b++) begin
            w = {};
            for (int i = 0; i < 100; i++)
                w.push_back((b == 0) ? $urandom() : 32'($urandom_range(0, 20)));
            run_batch(1, w, 2, 1, 0, '0);
        end

        // Randomized DEPTH=4 batches.
        for (int b = 0; b < 6; b++) begin
            w = {};
            for (int i = 0; i < 4; i++) w.push_back($urandom_range(0, 1) ? $urandom() : 32'($urandom_range(0, 3)));
            run_batch(0, w, 2, 1, 0, '0);
        end

        // Reset pulsed mid-SORT abandons the batch.
        sel = 0;
        w = '{32'd8, 32'd6, 32'd4, 32'd2};
        load_words(w, 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_sort_busy", 64'(busy4), 64'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", 64'(out_valid4), 64'(0));
        check("mid_rst_busy", 64'(busy4), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("after_rst_in_ready", 64'(in_ready4), 64'(1));
        check("after_rst_busy", 64'(busy4), 64'(0));
        saw_out = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (out_valid4 || busy4) saw_out = 1;
        end
        check("after_rst_no_output", 64'(saw_out), 64'(0));
        @(posedge clk); #1;
        out_ready = 1'b0;
        w = '{32'd4, 32'd3, 32'd2, 32'd1};
        run_batch(0, w, 0, 0, 0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bubble_sort_seq.md
Name: bubble_sort_seq

Overview:
Sequential, resource-shared bubble-sort engine. Loads DEPTH words over a valid/ready input stream into an internal register buffer, then sorts them ascending using a single shared compare-swap unit (one compare per clock), then streams the sorted words out over a valid/ready output stream. It is the multi-cycle, area-reduced replacement for the fully combinational sort network and produces the same output order for the same input set.

Parameters:
DATA_W, 32, data word width; values are unsigned.
DEPTH, 100, words per batch; static requirement DEPTH >= 2.
IDX_W, $clog2(DEPTH), index/counter width (derived, not overridden).

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  input word valid
in_ready  out  1  engine accepts an input word
in_data  in  DATA_W  input word
out_valid  out  1  sorted word valid
out_ready  in  1  downstream accepts the sorted word
out_data  out  DATA_W  sorted word, ascending order
out_last  out  1  high with the final (DEPTH-th) output word
busy  out  1  high in SORT or DRAIN
sort_cycles  out  32  clocks spent in SORT for the most recent batch; held until next SORT entry

Behaviour:
- Interface: one clock domain, clk; reset rst is synchronous and active-high.
- Reset: state=LOAD, wr_idx=0, rd_idx=0, j=0, limit=DEPTH-1, swapped=0, sort_cycles=0. While rst=1: in_ready=0, out_valid=0, out_last=0, busy=0, out_data=0. Buffer contents are not reset and are don't-care.
- Reset mid-operation (any state): the batch is abandoned. No partial output. Next batch starts with LOAD.
- LOAD:
  - in_ready=1. On in_valid&&in_ready: buf[wr_idx] <= in_data; wr_idx++.
  - Accepting word DEPTH-1 moves to SORT next cycle with j=0, limit=DEPTH-1, swapped=0, sort_cycles=0.
- SORT:
  - in_ready=0. Each cycle, compare_swap on buf[j], buf[j+1]. If buf[j] > buf[j+1] (strictly), swap both and set swapped.
  - Equal values are never swapped, so the sort is stable.
  - sort_cycles++ each cycle.
  - If j < limit-1: j++.
  - Pass end (j==limit-1): the swap flag includes this cycle's swap.
    - If no swap occurred in the pass, or limit==1: go to DRAIN, rd_idx=0.
    - Otherwise: limit--, j=0, swapped=0.
- SORT cost:
  - Already-sorted input: exactly DEPTH-1 cycles.
  - Worst case (reverse-sorted): DEPTH*(DEPTH-1)/2 cycles, i.e. 4950 for DEPTH=100.
- DRAIN:
  - out_valid=1, out_data=buf[rd_idx], out_last=(rd_idx==DEPTH-1).
  - Advance rd_idx only on out_valid&&out_ready. out_data and out_last stay stable under backpressure.
  - The handshake on the last word moves to LOAD next cycle with wr_idx=0. in_ready is 0 in that handshake cycle (no LOAD/DRAIN overlap).
- busy = (state==SORT || state==DRAIN).
- No saturation or wrap issues: indices never exceed DEPTH-1. sort_cycles is 32 bits and cannot overflow for DEPTH <= 92681.
- in_valid while in_ready=0 is ignored; the data is not consumed.

Decomposition:
- Package sort_pkg holds:
  - state enum sort_state_e {S_LOAD, S_SORT, S_DRAIN};
  - default DATA_W/DEPTH constants;
  - a localparam function for the worst-case cycle count, used by the bench.
- Sub-module compare_swap: purely combinational. Ports a, b in; lo, hi, swap out; swap = a > b unsigned. Instantiated once: it is the shared resource.

Test Plan:
- DEPTH=4, input 3,1,2,0 -> output 0,1,2,3; out_last on word 4; sort_cycles=6.
- DEPTH=100, input 1..100 ascending -> identical output; sort_cycles=99.
- DEPTH=100, input 100..1 descending -> output 1..100; sort_cycles=4950.
- DEPTH=4, input 7,7,1,0xFFFFFFFF -> output 1,7,7,0xFFFFFFFF (unsigned compare, duplicates kept); two back-to-back batches with in_valid held high -> second batch accepted only after first out_last handshake.
- DRAIN with out_ready toggling 1,0,0,1,... -> out_data/out_last stable while stalled; no word dropped or duplicated.
- rst pulsed mid-SORT -> next cycle in_ready=1, busy=0, no output produced; a fresh batch 4,3,2,1 (DEPTH=4) then sorts correctly to 1,2,3,4.
